// File: rtl/fir_reload_pkg.sv
// fir_reload_pkg: controller state type and default FIR sizing
package fir_reload_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_e;
  localparam int NUM_TAPS = 21;
  localparam int COEFF_W = 14;
  localparam int FIR_LATENCY = 2;
  localparam int CHECKSUM_W = 16;
endpackage

// File: rtl/fir_reload_counter.sv
// fir_reload_counter: up-counter with clear, enable and terminal-count compare
module fir_reload_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == term;
endmodule

// File: rtl/fir_reload_ctrl.sv
// fir_reload_ctrl: sequences FIR coefficient reload through IDLE/LOAD/FLUSH/RUN.
// Defining FIR_RELOAD_CHECKSUM_EN adds checksum verification of each load.
import fir_reload_pkg::*;
module fir_reload_ctrl #(
  parameter int CoefficientLengthBits = COEFF_W,
  parameter int NumTaps = NUM_TAPS,
`ifdef FIR_RELOAD_CHECKSUM_EN
  parameter int ChecksumBits = CHECKSUM_W,
`endif
  parameter int FirLatency = FIR_LATENCY
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_start,
  input  logic [CoefficientLengthBits-1:0] cfg_coeff,
  input  logic                             cfg_valid,
`ifdef FIR_RELOAD_CHECKSUM_EN
  input  logic [ChecksumBits-1:0]          cfg_checksum,
  output logic                             cfg_error,
`endif
  output logic                             cfg_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             fir_rst,
  output logic                             coeff_shift_en,
  output logic [CoefficientLengthBits-1:0] coeff_shift_data,
  output logic                             out_valid
);
  localparam int CntW = $clog2(NumTaps + FirLatency);
  state_e state, state_n;
  logic accept, last, flush_end, restart, ok, tc;
  logic [CntW-1:0] term;
  always_comb begin
    accept = state == LOAD && cfg_valid;
    last = accept && tc;
    flush_end = state == FLUSH && tc;
    restart = cfg_start && state != LOAD;
    term = state == LOAD ? CntW'(NumTaps - 1) : CntW'(NumTaps + FirLatency - 2);
    state_n = restart ? LOAD : last ? (ok ? FLUSH : IDLE) : flush_end ? RUN : state;
  end
  // one counter serves both the coefficient count and the flush wait
  fir_reload_counter #(.W(CntW)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(restart || last),
    .en(accept || state == FLUSH),
    .term(term),
    .tc(tc)
  );
  assign cfg_ready = state == LOAD;
  assign busy = state == LOAD || state == FLUSH;
  assign fir_rst = state == IDLE || state == LOAD;
  assign out_valid = state == RUN;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      coeff_shift_en <= 1'b0;
      coeff_shift_data <= '0;
    end else begin
      state <= state_n;
      done <= flush_end && !restart;
      coeff_shift_en <= accept;
      if (accept) coeff_shift_data <= cfg_coeff;
    end
`ifdef FIR_RELOAD_CHECKSUM_EN
  logic [ChecksumBits-1:0] sum, sum_n, chk_q;
  assign sum_n = sum + ChecksumBits'($signed(cfg_coeff));
  assign ok = sum_n == chk_q;
  always_ff @(posedge clk)
    if (rst) begin
      sum <= '0;
      chk_q <= '0;
      cfg_error <= 1'b0;
    end else begin
      cfg_error <= last && !ok;
      if (restart) begin
        sum <= '0;
        chk_q <= cfg_checksum;
      end else if (accept) sum <= sum_n;
    end
`else
  assign ok = 1'b1;
`endif
endmodule

// File: tb/tb_fir_reload_ctrl.sv
// tb_fir_reload_ctrl: scoreboard bench for the FIR reload controller (FIR_RELOAD_CHECKSUM_EN adds checksum cases)
module tb_fir_reload_ctrl;
  logic clk = 0, rst = 1, cfg_start = 0, cfg_valid = 0;
  logic [13:0] cfg_coeff = '0;
  logic cfg_ready, busy, done, fir_rst, coeff_shift_en, out_valid;
  logic [13:0] coeff_shift_data;
`ifdef FIR_RELOAD_CHECKSUM_EN
  logic [15:0] cfg_checksum = 16'd16384;
  logic cfg_error;
`endif
  int total = 0, bad = 0, nshift = 0, ndone = 0, nready = 0;
  logic acc = 0, ov_seen = 0;
  logic [13:0] sb[$];
  int h[21] = '{-61, 63, 173, -120, -300, 250, 600, -500, 1200, 3000, 7774,
                3000, 1200, -500, 600, 250, -300, -120, 173, 63, -61};
  always #5 clk = ~clk;
  fir_reload_ctrl dut (
    .clk(clk),
    .rst(rst),
    .cfg_start(cfg_start),
    .cfg_coeff(cfg_coeff),
    .cfg_valid(cfg_valid),
`ifdef FIR_RELOAD_CHECKSUM_EN
    .cfg_checksum(cfg_checksum),
    .cfg_error(cfg_error),
`endif
    .cfg_ready(cfg_ready),
    .busy(busy),
    .done(done),
    .fir_rst(fir_rst),
    .coeff_shift_en(coeff_shift_en),
    .coeff_shift_data(coeff_shift_data),
    .out_valid(out_valid)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start;
    cfg_start = 1;
    tick;
    cfg_start = 0;
    nready = 0;
  endtask
  task automatic send(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1;
      cfg_coeff = 14'(h[i]);
      check("ready_in_load", cfg_ready, 1);
      sb.push_back(14'(h[i]));
      tick;
      cfg_valid = 0;
      if (gap && i < n - 1) tick;
    end
  endtask
  task automatic wait_run(input int exp);
    int n = 0;
    while (!out_valid && n < 60) begin
      tick;
      n++;
    end
    check("flush_len", n, exp);
    check("done_rise", done, 1);
    tick;
    check("done_width", {done, out_valid}, 2'b01);
  endtask
  always @(posedge clk) acc <= cfg_valid && cfg_ready && !rst;
  always @(negedge clk) begin
    if (acc || coeff_shift_en) check("shift_timing", coeff_shift_en, acc);
    if (coeff_shift_en) begin
      nshift++;
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else check("shift_data", coeff_shift_data, sb.pop_front());
    end
    if (done) ndone++;
    if (out_valid) ov_seen = 1;
    if (cfg_ready) nready++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 20; i++) begin
      tick;
      check("reset_outs", {fir_rst, cfg_ready, busy, done, coeff_shift_en, out_valid, coeff_shift_data},
            {1'b1, 5'b0, 14'b0});
    end
    rst = 0;
    tick;
    check("idle_outs", {fir_rst, cfg_ready, busy}, 3'b100);
    start;
    check("load_entry", {busy, cfg_ready, fir_rst}, 3'b111);
    send(21, 0);
    check("clean_load_len", nready, 21);
    check("flush_entry", {busy, cfg_ready, fir_rst}, 3'b100);
    wait_run(22);
    check("clean_shifts", nshift, 21);
    start;
    check("reload_from_run", {out_valid, fir_rst, cfg_ready}, 3'b011);
    send(21, 1);
    check("gappy_load_len", nready, 41);
    check("gappy_flush_entry", {busy, cfg_ready, fir_rst}, 3'b100);
    wait_run(22);
    check("gappy_shifts", nshift, 42);
    start;
    send(21, 0);
    repeat (10) tick;
    ov_seen = 0;
    start;
    check("abort_to_load", {cfg_ready, fir_rst, busy, out_valid}, 4'b1110);
    repeat (30) tick;
    check("abort_no_valid", ov_seen, 0);
    send(12, 0);
    rst = 1;
    tick;
    rst = 0;
    check("rst_mid_load", {fir_rst, cfg_ready, busy, out_valid}, 4'b1000);
    check("rst_sb_drained", sb.size(), 0);
    tick;
    start;
    send(21, 0);
    wait_run(22);
    check("total_shifts", nshift, 96);
    check("done_count", ndone, 3);
`ifdef FIR_RELOAD_CHECKSUM_EN
    start;
    send(21, 0);
    wait_run(22);
    check("cs_good_done", ndone, 4);
    cfg_checksum = 16'd16385;
    start;
    ov_seen = 0;
    send(21, 0);
    check("cs_err", {cfg_error, cfg_ready, busy, fir_rst}, 4'b1001);
    tick;
    check("cs_err_width", cfg_error, 0);
    repeat (30) tick;
    check("cs_err_no_valid", ov_seen, 0);
    check("cs_err_no_done", ndone, 4);
`endif
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
